// File: rtl/operand_unpacker.sv
// operand_unpacker: fetches 64-bit memory words over an inclusive address
// range and hands them to the ALU front end as two DATA_W-bit operands, one
// per valid/ready handshake.
// Optional build macro UNPACK_SWAP_EN: emit the upper half of each word first.
// Without it the lower half goes first, matching the packer placing the first
// result in the low bits.
module operand_unpacker #(
  parameter int DATA_W        = 32,
  parameter int MEM_WORD_SIZE = 64,
  parameter int ADDR_W        = 10
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     start_i,
  input  logic [ADDR_W-1:0]        start_addr_i,
  input  logic [ADDR_W-1:0]        end_addr_i,
  output logic                     mem_rd_en_o,
  output logic [ADDR_W-1:0]        mem_addr_o,
  input  logic [MEM_WORD_SIZE-1:0] mem_rdata_i,
  output logic [DATA_W-1:0]        op_data_o,
  output logic                     op_valid_o,
  input  logic                     op_ready_i,
  output logic                     op_last_o,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     err_o
);

  typedef enum logic [2:0] {
    IDLE,
    READ,
    WAIT,
    EMIT_LO,
    EMIT_HI,
    DONE
  } state_t;

  state_t                   state;
  state_t                   state_next;
  logic [MEM_WORD_SIZE-1:0] word_buf;
  logic [ADDR_W-1:0]        addr_cnt;
  logic [ADDR_W-1:0]        end_addr;
  logic                     err_flag;
  logic                     range_bad;
  logic                     is_last;
  logic [DATA_W-1:0]        first_half;
  logic [DATA_W-1:0]        second_half;

  assign range_bad = (end_addr_i < start_addr_i);
  // Termination compares before incrementing, so the top address never wraps.
  assign is_last   = (addr_cnt == end_addr);
  assign err_o     = err_flag;

`ifdef UNPACK_SWAP_EN
  assign first_half  = word_buf[MEM_WORD_SIZE-1:DATA_W];
  assign second_half = word_buf[DATA_W-1:0];
`else
  assign first_half  = word_buf[DATA_W-1:0];
  assign second_half = word_buf[MEM_WORD_SIZE-1:DATA_W];
`endif

  // State register; reset has priority over a coincident start.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Datapath: range capture, word buffer, address counter and sticky error.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      word_buf <= '0;
      addr_cnt <= '0;
      end_addr <= '0;
      err_flag <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_i) begin
            if (range_bad) begin
              err_flag <= 1'b1;
            end else begin
              addr_cnt <= start_addr_i;
              end_addr <= end_addr_i;
              err_flag <= 1'b0;
            end
          end
        end
        WAIT: begin
          word_buf <= mem_rdata_i;
        end
        EMIT_HI: begin
          if (op_ready_i && !is_last) begin
            addr_cnt <= addr_cnt + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Next-state and output decode; outputs are pure functions of state so they
  // hold steady while the consumer stalls.
  always_comb begin
    state_next  = state;
    mem_rd_en_o = 1'b0;
    mem_addr_o  = '0;
    op_data_o   = '0;
    op_valid_o  = 1'b0;
    op_last_o   = 1'b0;
    busy_o      = (state != IDLE);
    done_o      = 1'b0;
    case (state)
      IDLE: begin
        if (start_i) begin
          state_next = range_bad ? DONE : READ;
        end
      end
      READ: begin
        mem_rd_en_o = 1'b1;
        mem_addr_o  = addr_cnt;
        state_next  = WAIT;
      end
      WAIT: begin
        state_next = EMIT_LO;
      end
      EMIT_LO: begin
        op_data_o  = first_half;
        op_valid_o = 1'b1;
        if (op_ready_i) begin
          state_next = EMIT_HI;
        end
      end
      EMIT_HI: begin
        op_data_o  = second_half;
        op_valid_o = 1'b1;
        op_last_o  = is_last;
        if (op_ready_i) begin
          state_next = is_last ? DONE : READ;
        end
      end
      DONE: begin
        done_o     = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_operand_unpacker.sv
// Testbench for operand_unpacker: a memory model answers reads one cycle
// later, and a range-level reference model predicts the read addresses and
// the operand stream. Define UNPACK_SWAP_EN here too when building that variant.
module tb_operand_unpacker;

  localparam int DATA_W = 32;
  localparam int MEM_W  = 64;
  localparam int ADDR_W = 10;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic              start_i;
  logic [ADDR_W-1:0] start_addr_i;
  logic [ADDR_W-1:0] end_addr_i;
  logic              mem_rd_en_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [MEM_W-1:0]  mem_rdata_i;
  logic [DATA_W-1:0] op_data_o;
  logic              op_valid_o;
  logic              op_ready_i;
  logic              op_last_o;
  logic              busy_o;
  logic              done_o;
  logic              err_o;

  logic [MEM_W-1:0]  mem [0:DEPTH-1];
  int                exp_addr_q[$];
  logic [DATA_W:0]   exp_op_q[$];
  int                errors = 0;
  int                checks = 0;
  int                read_count = 0;
  int                done_count = 0;
  int                ready_mode = 0;

  operand_unpacker #(.DATA_W(DATA_W), .MEM_WORD_SIZE(MEM_W), .ADDR_W(ADDR_W)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i),
    .start_addr_i(start_addr_i), .end_addr_i(end_addr_i),
    .mem_rd_en_o(mem_rd_en_o), .mem_addr_o(mem_addr_o), .mem_rdata_i(mem_rdata_i),
    .op_data_o(op_data_o), .op_valid_o(op_valid_o), .op_ready_i(op_ready_i),
    .op_last_o(op_last_o), .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  // Memory: data for a strobed address appears one cycle later; junk otherwise.
  always @(posedge clk_i) begin
    if (mem_rd_en_o) mem_rdata_i <= mem[mem_addr_o];
    else             mem_rdata_i <= {$urandom, $urandom};
  end

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Consumer ready: always high, random, or left to the test sequence.
  initial begin
    op_ready_i = 1'b1;
    forever begin
      @(posedge clk_i);
      #1;
      if (ready_mode == 0) op_ready_i = 1'b1;
      else if (ready_mode == 1) op_ready_i = 1'($urandom_range(0, 1));
    end
  end

  // Monitor: reads and handshakes against the model queues, plus stall stability.
  logic              prev_stall = 1'b0;
  logic [DATA_W-1:0] prev_data;
  logic              prev_last;
  always @(negedge clk_i) begin
    if (rst_i) begin
      prev_stall = 1'b0;
    end else begin
      if (done_o) done_count++;
      if (mem_rd_en_o) begin
        read_count++;
        if (exp_addr_q.size() == 0) checkOutput("unexpected_read", 1, 0);
        else checkOutput("mem_addr", mem_addr_o, exp_addr_q.pop_front());
      end
      if (prev_stall) begin
        checkOutput("stall_valid", op_valid_o, 1);
        checkOutput("stall_data", op_data_o, prev_data);
        checkOutput("stall_last", op_last_o, prev_last);
      end
      if (op_valid_o && op_ready_i) begin
        if (exp_op_q.size() == 0) begin
          checkOutput("unexpected_op", 1, 0);
        end else begin
          logic [DATA_W:0] e;
          e = exp_op_q.pop_front();
          checkOutput("op_data", op_data_o, e[DATA_W-1:0]);
          checkOutput("op_last", op_last_o, e[DATA_W]);
        end
      end
      prev_stall = op_valid_o && !op_ready_i;
      prev_data  = op_data_o;
      prev_last  = op_last_o;
    end
  end

  // Reference model: word order over the range, halves in emission order.
  task automatic prepareRange(input int s, input int e);
    exp_addr_q.delete();
    exp_op_q.delete();
    for (int a = s; a <= e; a++) begin
      logic [MEM_W-1:0] w;
      w = mem[a];
      exp_addr_q.push_back(a);
`ifdef UNPACK_SWAP_EN
      exp_op_q.push_back({1'b0, w[63:32]});
      exp_op_q.push_back({1'(a == e), w[31:0]});
`else
      exp_op_q.push_back({1'b0, w[31:0]});
      exp_op_q.push_back({1'(a == e), w[63:32]});
`endif
    end
  endtask

  task automatic applyStimulus(input int s, input int e);
    @(posedge clk_i);
    #1;
    start_i      = 1'b1;
    start_addr_i = ADDR_W'(s);
    end_addr_i   = ADDR_W'(e);
    @(posedge clk_i);
    #1;
    start_i = 1'b0;
  endtask

  task automatic finishRun(input bit bad, input int exp_reads, input int rd0, input int dn0);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 2000; k++) begin
      @(negedge clk_i);
      if (done_o) begin
        seen = 1'b1;
        break;
      end
    end
    checkOutput("done_seen", seen, 1);
    checkOutput("err_flag", err_o, bad);
    @(negedge clk_i);
    checkOutput("done_one_cycle", done_o, 0);
    checkOutput("idle_busy", busy_o, 0);
    checkOutput("read_count", read_count - rd0, exp_reads);
    checkOutput("done_count", done_count - dn0, 1);
    checkOutput("ops_left", exp_op_q.size(), 0);
  endtask

  task automatic runRange(input int s, input int e);
    int rd0, dn0, lat;
    bit bad;
    bad = (e < s);
    if (bad) begin
      exp_addr_q.delete();
      exp_op_q.delete();
    end else begin
      prepareRange(s, e);
    end
    rd0 = read_count;
    dn0 = done_count;
    applyStimulus(s, e);
    if (!bad) begin
      lat = 0;
      for (int k = 1; k <= 10; k++) begin
        @(negedge clk_i);
        if (op_valid_o) begin
          lat = k;
          break;
        end
      end
      checkOutput("first_valid_latency", lat, 3);
    end
    finishRun(bad, bad ? 0 : (e - s + 1), rd0, dn0);
  endtask

  initial begin
    int rd0, dn0, s, e;
    bit seen;
    for (int i = 0; i < DEPTH; i++) mem[i] = {$urandom, $urandom};
    rst_i = 1'b1;
    start_i = 1'b0;
    start_addr_i = '0;
    end_addr_i = '0;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    checkOutput("reset_outputs",
                {mem_rd_en_o, mem_addr_o, op_data_o, op_valid_o, op_last_o, busy_o, done_o, err_o}, 0);
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;

    // Single word.
    mem[5] = 64'h1111_2222_3333_4444;
    runRange(5, 5);

    // Three consecutive words.
    runRange(0, 2);

    // Backpressure in both halves, with an ignored start while busy.
    prepareRange(0, 1);
    ready_mode = 2;
    op_ready_i = 1'b0;
    rd0 = read_count;
    dn0 = done_count;
    applyStimulus(0, 1);
    seen = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk_i);
      if (op_valid_o) begin
        seen = 1'b1;
        break;
      end
    end
    checkOutput("bp_valid_seen", seen, 1);
    applyStimulus(100, 100);
    op_ready_i = 1'b1;
    @(posedge clk_i);
    #1;
    op_ready_i = 1'b0;
    rd0 = read_count;
    repeat (4) @(posedge clk_i);
    @(negedge clk_i);
    checkOutput("bp_hi_valid", op_valid_o, 1);
    checkOutput("bp_hi_data", op_data_o, exp_op_q[0][DATA_W-1:0]);
    checkOutput("bp_no_read", read_count - rd0, 0);
    ready_mode = 0;
    finishRun(1'b0, 1, rd0, dn0);

    // Bad range, then a good range clears the error.
    runRange(7, 3);
    runRange(2, 3);

    // Reset while WAITing for the first word of 0..3.
    prepareRange(0, 0);
    exp_op_q.delete();
    dn0 = done_count;
    applyStimulus(0, 3);
    @(posedge clk_i);
    #1;
    rst_i = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    checkOutput("midreset_outputs",
                {mem_rd_en_o, mem_addr_o, op_data_o, op_valid_o, op_last_o, busy_o, done_o, err_o}, 0);
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    checkOutput("midreset_no_done", done_count - dn0, 0);
    checkOutput("midreset_reads_left", exp_addr_q.size(), 0);
    runRange(0, 0);

    // Top of the address space: no wrap to address 0.
    runRange(DEPTH - 1, DEPTH - 1);
    repeat (5) @(posedge clk_i);

    // Randomized ranges with random backpressure.
    ready_mode = 1;
    for (int n = 0; n < 10; n++) begin
      s = $urandom_range(0, DEPTH - 5);
      e = s + $urandom_range(0, 3);
      runRange(s, e);
    end
    ready_mode = 0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
